// File: rtl/game_countdown_timer_if.sv
// Control and display signals between the game controller, the countdown timer and the seven-segment drivers.
interface game_countdown_timer_if;
  logic       Enable;
  logic       Reconfig;
  logic [3:0] Sec_Tens;
  logic [3:0] Sec_Ones;
  logic       TimeUp;
  logic       Running;
  logic       Warning;
  logic       SecTick;

  modport master (
    output Enable, Reconfig,
    input  Sec_Tens, Sec_Ones, TimeUp, Running, Warning, SecTick
  );

  modport slave (
    input  Enable, Reconfig,
    output Sec_Tens, Sec_Ones, TimeUp, Running, Warning, SecTick
  );
endinterface

// File: rtl/game_countdown_timer.sv
// Round countdown timer: a prescaled one-second tick decrements a two-digit BCD count.
// The count reaches 00 in the EXPIRED state, which raises TimeUp until Reconfig or Reset.
module game_countdown_timer #(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned GAME_SECONDS = 60,
  parameter int unsigned WARN_SECONDS = 10
) (
  input  logic                  Clock,
  input  logic                  Reset,
  game_countdown_timer_if.slave bus
);

  localparam int unsigned PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned WARN_CLAMP = (WARN_SECONDS > 99) ? 99 : WARN_SECONDS;
  localparam logic [3:0]  FULL_TENS  = 4'(GAME_SECONDS / 10);
  localparam logic [3:0]  FULL_ONES  = 4'(GAME_SECONDS % 10);
  localparam logic [3:0]  WARN_TENS  = 4'(WARN_CLAMP / 10);
  localparam logic [3:0]  WARN_ONES  = 4'(WARN_CLAMP % 10);
  localparam logic        FULL_WARN  = 1'(GAME_SECONDS <= WARN_SECONDS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_EXPIRED
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic             timeup_q, timeup_d;
  logic             running_q, running_d;
  logic             warning_q, warning_d;
  logic             sectick_q, sectick_d;

  // State, count and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      tens_q    <= FULL_TENS;
      ones_q    <= FULL_ONES;
      timeup_q  <= 1'b0;
      running_q <= 1'b0;
      warning_q <= FULL_WARN;
      sectick_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      timeup_q  <= timeup_d;
      running_q <= running_d;
      warning_q <= warning_d;
      sectick_q <= sectick_d;
    end
  end

  // Next state, prescaler and BCD count; outputs derive from the post-update values
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    sectick_d = 1'b0;

    if (bus.Reconfig) begin
      state_d = S_IDLE;
      pre_d   = '0;
      tens_d  = FULL_TENS;
      ones_d  = FULL_ONES;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.Enable) state_d = S_RUN;
        end
        S_RUN: begin
          if (bus.Enable) begin
            if (pre_q == PRE_LAST) begin
              pre_d     = '0;
              sectick_d = 1'b1;
              if (ones_q == 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
              end else begin
                ones_d = ones_q - 4'd1;
              end
              if (tens_q == 4'd0 && ones_q == 4'd1) state_d = S_EXPIRED;
            end else begin
              pre_d = pre_q + PRE_W'(1);
            end
          end
        end
        S_EXPIRED: begin
          tens_d = 4'd0;
          ones_d = 4'd0;
        end
        default: state_d = S_IDLE;
      endcase
    end

    running_d = (state_d == S_RUN);
    timeup_d  = (state_d == S_EXPIRED);
    warning_d = (state_d != S_EXPIRED) &&
                ((tens_d < WARN_TENS) || ((tens_d == WARN_TENS) && (ones_d <= WARN_ONES)));
  end

  assign bus.Sec_Tens = tens_q;
  assign bus.Sec_Ones = ones_q;
  assign bus.TimeUp   = timeup_q;
  assign bus.Running  = running_q;
  assign bus.Warning  = warning_q;
  assign bus.SecTick  = sectick_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Bench for game_countdown_timer: directed scenarios and random control traffic against an integer-seconds model.
module tb_game_countdown_timer;

  localparam int TD = 4;
  localparam int GS = 12;
  localparam int WS = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_EXP = 2;

  logic clk = 1'b0;
  logic rst_r = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  // Model: remaining seconds, enabled cycles into the current second, phase
  int   m_sec = GS;
  int   m_pre = 0;
  int   m_mode = M_IDLE;
  logic m_tick = 1'b0;

  game_countdown_timer_if bus ();

  game_countdown_timer #(
    .TICK_DIV    (TD),
    .GAME_SECONDS(GS),
    .WARN_SECONDS(WS)
  ) dut (
    .Clock(clk),
    .Reset(rst_r),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] dut_vec();
    return {bus.Sec_Tens, bus.Sec_Ones, bus.TimeUp, bus.Running, bus.Warning, bus.SecTick};
  endfunction

  function automatic logic [11:0] exp_vec();
    logic [3:0] t, o;
    t = 4'(m_sec / 10);
    o = 4'(m_sec % 10);
    return {t, o, 1'(m_mode == M_EXP), 1'(m_mode == M_RUN),
            1'(m_mode != M_EXP && m_sec <= WS), m_tick};
  endfunction

  // Drive one clock of inputs and advance the model by the rules of the game timer
  task automatic step(input logic rst, input logic rc, input logic en);
    rst_r = rst;
    bus.Reconfig = rc;
    bus.Enable = en;
    @(posedge clk);
    m_tick = 1'b0;
    if (rst || rc) begin
      m_sec = GS; m_pre = 0; m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (en) m_mode = M_RUN;
    end else if (m_mode == M_RUN && en) begin
      m_pre = m_pre + 1;
      if (m_pre == TD) begin
        m_pre = 0;
        m_sec = m_sec - 1;
        m_tick = 1'b1;
        if (m_sec == 0) m_mode = M_EXP;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (dut_vec() !== 12'h120) begin
      n_fail++; $display("FAIL reset_values: got %h want %h", dut_vec(), 12'h120);
    end
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model: got %h want %h", dut_vec(), exp_vec());
    end
    step(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (dut_vec() !== 12'h120) begin
      n_fail++; $display("FAIL idle_hold: got %h want %h", dut_vec(), 12'h120);
    end
  endtask

  task automatic test_countdown();
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (bus.Running !== 1'b1) begin
      n_fail++; $display("FAIL enter_run: Running got %b want 1", bus.Running);
    end
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL countdown_cycle%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      if (k == 4) begin
        n_checks++;
        if ({bus.Sec_Tens, bus.Sec_Ones, bus.SecTick} !== {8'h11, 1'b1}) begin
          n_fail++; $display("FAIL first_tick: got %h%h tick %b want 11 tick 1",
                             bus.Sec_Tens, bus.Sec_Ones, bus.SecTick);
        end
      end
      if (k == 5) begin
        n_checks++;
        if (bus.SecTick !== 1'b0) begin
          n_fail++; $display("FAIL tick_single: SecTick got %b want 0", bus.SecTick);
        end
      end
      if (k == 8) begin
        n_checks++;
        if ({bus.Sec_Tens, bus.Sec_Ones, bus.Warning} !== {8'h10, 1'b1}) begin
          n_fail++; $display("FAIL warn_at_10: got %h%h warn %b want 10 warn 1",
                             bus.Sec_Tens, bus.Sec_Ones, bus.Warning);
        end
      end
      if (k == 12) begin
        n_checks++;
        if ({bus.Sec_Tens, bus.Sec_Ones} !== 8'h09) begin
          n_fail++; $display("FAIL borrow: got %h%h want 09", bus.Sec_Tens, bus.Sec_Ones);
        end
      end
    end
  endtask

  task automatic test_expire();
    int guard;
    guard = 0;
    while (m_mode != M_EXP && guard < 100) begin
      step(1'b0, 1'b0, 1'b1);
      guard++;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL run_down: got %h want %h", dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if ({bus.Sec_Tens, bus.Sec_Ones, bus.TimeUp, bus.Running, bus.Warning} !== {8'h00, 3'b100}) begin
      n_fail++; $display("FAIL expire_edge: got %h want %h (guard %0d)", dut_vec(), 12'h009, guard);
    end
    for (int k = 0; k < 50; k++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      n_checks++;
      if (dut_vec() !== 12'h008) begin
        n_fail++; $display("FAIL expired_hold%0d: got %h want %h", k, dut_vec(), 12'h008);
      end
    end
  endtask

  task automatic test_pause();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (dut_vec() !== 12'h124) begin
        n_fail++; $display("FAIL pause_freeze%0d: got %h want %h", k, dut_vec(), 12'h124);
      end
    end
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (dut_vec() !== 12'h124) begin
      n_fail++; $display("FAIL resume_early: got %h want %h", dut_vec(), 12'h124);
    end
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (dut_vec() !== 12'h115) begin
      n_fail++; $display("FAIL resume_tick: got %h want %h", dut_vec(), 12'h115);
    end
  endtask

  task automatic test_reconfig_tick();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (dut_vec() !== 12'h120) begin
      n_fail++; $display("FAIL reconfig_tick: got %h want %h", dut_vec(), 12'h120);
    end
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({bus.Sec_Tens, bus.Sec_Ones} !== 8'h12) begin
        n_fail++; $display("FAIL reconfig_no11_%0d: got %h%h want 12", k, bus.Sec_Tens, bus.Sec_Ones);
      end
    end
  endtask

  task automatic test_reset_expired();
    int guard;
    guard = 0;
    while (m_mode != M_EXP && guard < 100) begin
      step(1'b0, 1'b0, 1'b1);
      guard++;
    end
    n_checks++;
    if (bus.TimeUp !== 1'b1) begin
      n_fail++; $display("FAIL reach_expired: TimeUp got %b want 1 (guard %0d)", bus.TimeUp, guard);
    end
    step(1'b1, 1'b0, 1'b1);
    n_checks++;
    if ({bus.TimeUp, bus.Sec_Tens, bus.Sec_Ones, bus.Warning} !== {1'b0, 8'h12, 1'b0}) begin
      n_fail++; $display("FAIL reset_from_expired: got %h want %h", dut_vec(), 12'h120);
    end
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (dut_vec() !== 12'h115) begin
      n_fail++; $display("FAIL restart_countdown: got %h want %h", dut_vec(), 12'h115);
    end
  endtask

  task automatic test_random();
    logic rst, rc, en;
    for (int k = 0; k < 600; k++) begin
      rst = 1'($urandom_range(0, 99) < 2);
      rc  = 1'($urandom_range(0, 99) < 3);
      en  = 1'($urandom_range(0, 99) < 80);
      step(rst, rc, en);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.Enable = 1'b0;
    bus.Reconfig = 1'b0;
    test_reset();
    test_countdown();
    test_expire();
    test_pause();
    test_reconfig_tick();
    test_reset_expired();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
